cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Central controller for the two-layer CNN datapath. It sequences conv layer 1, pool layer 1, conv layer 2, pool layer 2 and the final fully-connected stage.
- Each stage is launched with a one-cycle start pulse. The sequencer then waits for that engine's done signal.
- It selects the ping-pong feature-map bank for each stage and supervises every stage with a timeout watchdog.
- It sits in top, between the host start/done interface and the conv, pool and FC engines.

Parameters:
- TMO_W, 20, width of the watchdog counter.
- TMO_CYCLES, 1000000, maximum cycles a stage may run before an error is flagged. Must be < 2^TMO_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to run one full inference; sampled only in IDLE, DONE or ERR.
- conv_start  out  1  one-cycle pulse launching the conv engine.
- conv_layer  out  1  0 = layer 1 weights/geometry, 1 = layer 2. Held stable for the whole conv stage.
- conv_done  in  1  conv engine completion; pulse or level.
- pool_start  out  1  one-cycle pulse launching the pool engine.
- pool_layer  out  1  0 = pool 1, 1 = pool 2. Held for the whole pool stage.
- pool_done  in  1  pool engine completion.
- fc_start  out  1  one-cycle pulse launching the FC stage.
- fc_done  in  1  FC completion.
- buf_sel  out  1  feature-map bank written by the active stage. The stage reads bank ~buf_sel.
- stage  out  3  current state encoding.
- busy  out  1  high in C1, P1, C2, P2 and FC.
- done  out  1  level, high in DONE.
- error  out  1  level, high in ERR.

Behaviour:
- Reset: state IDLE. All outputs 0, including all start pulses, conv_layer, pool_layer, buf_sel, busy, done and error. Watchdog counter cleared.
- Reset mid-operation returns to IDLE in the next cycle with no further start pulses. Engines are reset independently.
- States and stage encodings:
  - IDLE = 0, C1 = 1, P1 = 2, C2 = 3, P2 = 4, FC = 5, DONE = 6, ERR = 7.
- Launch from IDLE, DONE or ERR: start high at edge N → state C1 at cycle N+1.
  - done and error clear at N+1.
  - conv_start = 1 for cycle N+1 only.
- Stage pulse rule: every active state drives its engine's start pulse high for exactly its first cycle.
- Start while busy is ignored and has no side effects.
- Stage transitions, each advancing on the named done sampled high:
  - C1 on conv_done → P1.
  - P1 on pool_done → C2.
  - C2 on conv_done → P2.
  - P2 on pool_done → FC.
  - FC on fc_done → DONE.
- Transition timing: the next state and its start pulse appear in the cycle after done is sampled.
- Done sampling window: done is sampled only from the second cycle of a state onward. A done high in the start-pulse cycle is ignored, so a level left over from the previous stage cannot advance the sequencer.
- Only the done of the engine owning the current stage is observed. Other dones are ignored.
- Layer selects:
  - conv_layer = 0 in C1, 1 in C2.
  - pool_layer = 0 in P1, 1 in P2.
  - Both hold their last value elsewhere.
- buf_sel by state:
  - C1 = 0, P1 = 1, C2 = 0, P2 = 1, FC = 0.
  - IDLE, DONE and ERR: 0.
- Watchdog:
  - Counter clears on entry to each active state and increments every cycle in that state.
  - If the counter reaches TMO_CYCLES with the owning done low → ERR in the next cycle.
  - If done and timeout coincide in the same cycle, done wins and the stage advances normally.
- ERR:
  - error = 1, busy = 0, no pulses.
  - stage holds 7 until rst or start.
  - start restarts at C1 and clears error.
- DONE: done = 1, held until start or rst. start relaunches from C1.
- Latency with single-cycle engines: at least 2 cycles per stage. Minimum start-to-done is 11 cycles.

Test Plan:
1. Reset, then start at cycle 0; each engine returns done 5 cycles after its start pulse.
   - Pulses: conv_start at cycle 1, pool_start at 7, conv_start at 13, pool_start at 19, fc_start at 25.
   - done = 1 at cycle 31.
   - conv_layer and pool_layer toggle 0 → 1 at the correct stages.
   - buf_sel sequence: 0, 1, 0, 1, 0.
2. conv_done held high continuously from C1 into P1. Required: no advance out of P1 until pool_done rises; stage stays 2.
3. TMO_CYCLES = 16; pool_done never asserted in P1.
   - stage becomes 7 and error = 1 exactly 17 cycles after pool_start.
   - A subsequent start restarts at C1 with error = 0.
4. TMO_CYCLES = 16; conv_done asserted on the timeout cycle. Required: transition to P1, error stays 0.
5. start pulsed during C2, then rst asserted in P2.
   - No restart from the start pulse.
   - After rst: stage = 0, all outputs 0, no further start pulses.
6. start asserted while in DONE. Required: done drops and conv_start pulses in the next cycle with conv_layer = 0.

Source files
------------

// File: rtl/cnn_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer_if
// Handshake bundle between the layer sequencer, the host and the conv/pool/FC
// engines.
//   master : the sequencer side (drives engine launches, layer/bank selects and
//            host status; receives host start and engine completions).
//   slave  : the host/engine side (mirror of master).
// Signals:
//   start                  host request to run one inference
//   conv_start/conv_layer  conv engine launch pulse and layer select
//   conv_done              conv engine completion (pulse or level)
//   pool_start/pool_layer  pool engine launch pulse and layer select
//   pool_done              pool engine completion
//   fc_start/fc_done       FC stage launch pulse and completion
//   buf_sel                feature-map bank written by the active stage
//   stage                  current sequencer state encoding
//   busy/done/error        host status levels
// -----------------------------------------------------------------------------
interface cnn_layer_sequencer_if;
   logic       start;
   logic       conv_start;
   logic       conv_layer;
   logic       conv_done;
   logic       pool_start;
   logic       pool_layer;
   logic       pool_done;
   logic       fc_start;
   logic       fc_done;
   logic       buf_sel;
   logic [2:0] stage;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      input  start, conv_done, pool_done, fc_done,
      output conv_start, conv_layer, pool_start, pool_layer, fc_start,
             buf_sel, stage, busy, done, error
   );

   modport slave (
      output start, conv_done, pool_done, fc_done,
      input  conv_start, conv_layer, pool_start, pool_layer, fc_start,
             buf_sel, stage, busy, done, error
   );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
// Central controller of the two-layer CNN datapath. Runs conv1 -> pool1 ->
// conv2 -> pool2 -> FC, launching each engine with a one-cycle start pulse,
// waiting for its done, steering the ping-pong feature-map bank and guarding
// every stage with a timeout watchdog.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  cnn_layer_sequencer_if.master (host start/status, engine handshakes)
// Parameters:
//   TMO_W       watchdog counter width
//   TMO_CYCLES  stage cycle limit before ERR (must be < 2**TMO_W)
// -----------------------------------------------------------------------------
module cnn_layer_sequencer #(
   parameter int TMO_W      = 20,
   parameter int TMO_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   cnn_layer_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      C1   = 3'd1,
      P1   = 3'd2,
      C2   = 3'd3,
      P2   = 3'd4,
      FC   = 3'd5,
      DONE = 3'd6,
      ERR  = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic             first_q;        // high in the first cycle of every state
   logic [TMO_W-1:0] wd_q;
   logic             conv_layer_q;
   logic             pool_layer_q;

   logic             active;
   logic             owner_done;
   logic             done_seen;
   logic             timeout;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      active     = state_q inside {C1, P1, C2, P2, FC};
      owner_done = 1'b0;

      // Only the engine that owns the current stage is listened to.
      case (state_q)
         C1, C2:  owner_done = bus.conv_done;
         P1, P2:  owner_done = bus.pool_done;
         FC:      owner_done = bus.fc_done;
         default: owner_done = 1'b0;
      endcase

      // The start-pulse cycle is blind to done, so a level still high from the
      // previous run of the same engine cannot advance the stage.
      done_seen = owner_done && !first_q;
      timeout   = (wd_q == TMO_W'(TMO_CYCLES));

      case (state_q)
         IDLE, DONE, ERR: if (bus.start) state_d = C1;
         default: begin
            // done has priority over a coincident timeout
            if (done_seen) begin
               case (state_q)
                  C1:      state_d = P1;
                  P1:      state_d = C2;
                  C2:      state_d = P2;
                  P2:      state_d = FC;
                  default: state_d = DONE;
               endcase
            end else if (timeout) begin
               state_d = ERR;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, watchdog and layer-select registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         first_q      <= 1'b0;
         wd_q         <= '0;
         conv_layer_q <= 1'b0;
         pool_layer_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);

         // Cleared on every state change, counts while a stage runs.
         if ((state_d != state_q) || !active) wd_q <= '0;
         else                                  wd_q <= wd_q + TMO_W'(1);

         // Selects are loaded on stage entry and held everywhere else.
         if (state_d == C1)      conv_layer_q <= 1'b0;
         else if (state_d == C2) conv_layer_q <= 1'b1;

         if (state_d == P1)      pool_layer_q <= 1'b0;
         else if (state_d == P2) pool_layer_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.conv_start = first_q && (state_q inside {C1, C2});
      bus.pool_start = first_q && (state_q inside {P1, P2});
      bus.fc_start   = first_q && (state_q == FC);
      bus.conv_layer = conv_layer_q;
      bus.pool_layer = pool_layer_q;
      bus.buf_sel    = state_q inside {P1, P2};  // pool writes bank 1, others bank 0
      bus.stage      = state_q;
      bus.busy       = active;
      bus.done       = (state_q == DONE);
      bus.error      = (state_q == ERR);
   end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_sequencer
// Self-checking bench for cnn_layer_sequencer (TMO_CYCLES = 16). Expected
// per-cycle outputs for a full inference are derived from the stage latencies
// as a timeline: stage k begins one cycle after the done of stage k-1, lasts
// latency+1 cycles, and the layer/bank selects follow the stage table.
// -----------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

   logic clk;
   logic rst;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   cnn_layer_sequencer_if bus ();

   cnn_layer_sequencer #(
      .TMO_W      (20),
      .TMO_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timeline tables for one inference, indexed by cycle after launch.
   logic [11:0] exp_tab [0:255];
   logic [2:0]  drv_tab [0:255];   // {conv_done, pool_done, fc_done}
   logic        st_tab  [0:255];
   int          last;
   int          lat [5];
   logic        cl_m = 1'b0;       // model of held conv_layer
   logic        pl_m = 1'b0;       // model of held pool_layer

   function automatic logic [11:0] mk(input logic [2:0] st, input logic cs,
      input logic ps, input logic fs, input logic cl, input logic pl,
      input logic bs, input logic bz, input logic dn, input logic er);
      return {st, cs, ps, fs, cl, pl, bs, bz, dn, er};
   endfunction

   function automatic logic [11:0] obs();
      return {bus.stage, bus.conv_start, bus.pool_start, bus.fc_start,
              bus.conv_layer, bus.pool_layer, bus.buf_sel, bus.busy,
              bus.done, bus.error};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b (stage,cs,ps,fs,cl,pl,buf,busy,done,err)",
                tag, cyc, o, e);
      end
   endtask

   // Check the current cycle, then drive inputs for it and advance one edge.
   task automatic tick(input string tag, input logic [11:0] e, input logic [2:0] dn,
                       input logic st);
      check(tag, obs(), e);
      {bus.conv_done, bus.pool_done, bus.fc_done} = dn;
      bus.start = st;
      step();
   endtask

   // mode 0: clean engines; 1: random noise on non-owner dones, busy starts and
   // early own done; 2: non-owner dones held high constantly.
   task automatic build(input int mode);
      int         s;
      logic [2:0] ob;
      logic [2:0] noise;
      logic       own;
      s = 1;
      for (int k = 0; k < 5; k++) begin
         ob = (k == 4) ? 3'b001 : ((k % 2 == 0) ? 3'b100 : 3'b010);
         if (k == 0) cl_m = 1'b0;
         if (k == 2) cl_m = 1'b1;
         if (k == 1) pl_m = 1'b0;
         if (k == 3) pl_m = 1'b1;
         for (int c = s; c <= s + lat[k]; c++) begin
            exp_tab[c] = mk(3'(k + 1), ob[2] && (c == s), ob[1] && (c == s),
                            ob[0] && (c == s), cl_m, pl_m, 1'(k % 2), 1'b1, 1'b0, 1'b0);
            noise = (mode == 0) ? 3'b000 : ((mode == 1) ? 3'($urandom) : 3'b111);
            own   = (c == s + lat[k]) || ((mode != 0) && (c == s) && ($urandom_range(0, 1) == 1));
            drv_tab[c] = (noise & ~ob) | (own ? ob : 3'b000);
            st_tab[c]  = (mode != 0) && ($urandom_range(0, 3) == 0);
         end
         s = s + lat[k] + 1;
      end
      for (int c = s; c <= s + 2; c++) begin
         exp_tab[c] = mk(3'd6, 1'b0, 1'b0, 1'b0, cl_m, pl_m, 1'b0, 1'b0, 1'b1, 1'b0);
         drv_tab[c] = (mode == 0) ? 3'b000 : 3'($urandom);
         st_tab[c]  = 1'b0;
      end
      last = s + 2;
   endtask

   task automatic run_table(input string tag);
      bus.start = 1'b1;
      {bus.conv_done, bus.pool_done, bus.fc_done} = 3'b000;
      step();
      for (int c = 1; c <= last; c++) tick(tag, exp_tab[c], drv_tab[c], st_tab[c]);
      bus.start = 1'b0;
      {bus.conv_done, bus.pool_done, bus.fc_done} = 3'b000;
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      {bus.conv_done, bus.pool_done, bus.fc_done} = 3'b000;
      step();

      // Reset state, then idle ignores stray engine dones
      tick("reset", 12'h000, 3'b111, 1'b0);
      tick("reset", 12'h000, 3'b000, 1'b0);
      rst = 1'b0;
      tick("idle", 12'h000, 3'b101, 1'b0);
      tick("idle", 12'h000, 3'b000, 1'b0);

      // Every engine answers 5 cycles after its pulse: pulses at 1,7,13,19,25,
      // done at 31
      lat = '{5, 5, 5, 5, 5};
      build(0);
      run_table("fixed5");

      // Random latencies (1..16, 16 = done on the timeout cycle), relaunched
      // from DONE each time
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 5; k++) lat[k] = int'($urandom_range(1, 16));
         build((r % 3 == 2) ? 2 : 1);
         run_table((r % 3 == 2) ? "rnd_level" : "rnd_noise");
      end

      // Timeout in P1: ERR exactly 17 cycles after pool_start
      tick("t3.done", mk(3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 3'b000, 1'b1);
      tick("t3.c1", mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 3'b000, 1'b0);
      tick("t3.c1", mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100, 1'b0);
      for (int j = 0; j <= 16; j++)
         tick("t3.p1", mk(3'd2, 1'b0, j == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0),
              {1'($urandom), 1'b0, 1'($urandom)}, 1'b0);
      for (int j = 0; j < 3; j++)
         tick("t3.err", mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
              3'($urandom), j == 2);

      // Restart from ERR; conv_done on the timeout cycle advances to P1
      for (int j = 0; j <= 15; j++)
         tick("t4.c1", mk(3'd1, j == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
              {1'b0, 1'($urandom), 1'($urandom)}, 1'b0);
      tick("t4.c1tmo", mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100, 1'b0);
      // pool_done in P1's pulse cycle is ignored, the next cycle advances
      tick("t4.p1", mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 3'b010, 1'b0);
      tick("t4.p1", mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 3'b010, 1'b0);

      // start during C2 is ignored; rst in P2 returns to IDLE with all outputs 0
      tick("t5.c2", mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b000, 1'b1);
      tick("t5.c2", mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'b100, 1'b0);
      tick("t5.p2", mk(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 3'b000, 1'b0);
      rst = 1'b1;
      tick("t5.p2", mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 3'b010, 1'b0);
      rst = 1'b0;
      cl_m = 1'b0;
      pl_m = 1'b0;
      for (int j = 0; j < 4; j++) tick("t5.rst", 12'h000, 3'($urandom), 1'b0);

      // One more random inference launched from IDLE after the reset
      for (int k = 0; k < 5; k++) lat[k] = int'($urandom_range(1, 16));
      build(1);
      run_table("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
